// File: rtl/mouse_proximity_scheduler_pkg.sv
// Shared constants and state encoding for the mouse proximity scheduler.
// No logic is defined here. It is imported by the scheduler and by the distance checker.
// Not applicable for backpressure. This package holds constants only.
package mouse_proximity_scheduler_pkg;

    // Q20.12 fixed point: the integer pixel part sits above bit 12
    localparam int FRAC_BITS    = 12;
    // An object counts as close below this many whole pixels on both axes
    localparam int CLOSE_THRESH = 20;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_READ = 2'd1,
        S_EVAL = 2'd2
    } state_t;

endpackage

// File: rtl/mouse_distance_checker.sv
// Combinational closeness and flee-direction test for one object against the mouse.
// Latency is zero cycles, because the design is purely combinational.
// There is no backpressure. The outputs follow the inputs directly.
module mouse_distance_checker
    import mouse_proximity_scheduler_pkg::*;
(
    input  logic [31:0] i_x_obj,
    input  logic [31:0] i_y_obj,
    input  logic [31:0] i_x_mouse,
    input  logic [31:0] i_y_mouse,
    output logic        o_is_close,
    output logic        o_direction
);

    logic [31:0] w_dx;
    logic [31:0] w_dy;
    logic [31:0] w_adx;
    logic [31:0] w_ady;

    // Wrapping differences; dy is mouse minus object (screen Y grows downward)
    assign w_dx = i_x_obj - i_x_mouse;
    assign w_dy = i_y_mouse - i_y_obj;

    // Two's-complement magnitude. 0x8000_0000 maps to itself and, compared
    // as unsigned, is far beyond the threshold, so it can never be close.
    assign w_adx = w_dx[31] ? (~w_dx + 32'd1) : w_dx;
    assign w_ady = w_dy[31] ? (~w_dy + 32'd1) : w_dy;

    assign o_is_close  = ((w_adx >> FRAC_BITS) < 32'(CLOSE_THRESH)) &&
                         ((w_ady >> FRAC_BITS) < 32'(CLOSE_THRESH));
    // Sign of dx: 1 means the object is left of the mouse
    assign o_direction = w_dx[31];

endmodule

// File: rtl/mouse_proximity_scheduler.sv
// Scans N_OBJ objects per frame tick and publishes close/direction masks coherently.
// Latency: done arrives 2*N_OBJ+1 cycles after start is sampled, using one READ and one EVAL cycle per object.
// No backpressure. A start arriving while busy is dropped, and a start in the done cycle is accepted.
module mouse_proximity_scheduler
    import mouse_proximity_scheduler_pkg::*;
#(
    parameter int N_OBJ = 8,
    parameter int IDX_W = (N_OBJ > 1) ? $clog2(N_OBJ) : 1
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_start,
    input  logic [31:0]      i_x_mouse,
    input  logic [31:0]      i_y_mouse,
    input  logic [N_OBJ-1:0] i_obj_enable,
    output logic [IDX_W-1:0] o_obj_idx,
    input  logic [31:0]      i_obj_x,
    input  logic [31:0]      i_obj_y,
    output logic             o_busy,
    output logic             o_done,
    output logic [N_OBJ-1:0] o_close_mask,
    output logic [N_OBJ-1:0] o_dir_mask,
    output logic             o_any_close
);

    state_t             r_state;
    state_t             w_state_nxt;
    logic [IDX_W-1:0]   r_idx;
    logic [31:0]        r_x_mouse;
    logic [31:0]        r_y_mouse;
    logic [N_OBJ-1:0]   r_enable;
    logic [N_OBJ-1:0]   r_close_sh;
    logic [N_OBJ-1:0]   r_dir_sh;
    logic [N_OBJ-1:0]   r_close_mask;
    logic [N_OBJ-1:0]   r_dir_mask;
    logic               r_any_close;
    logic               r_busy;
    logic               r_done;

    logic               w_is_close;
    logic               w_direction;
    logic               w_last;
    logic [N_OBJ-1:0]   w_close_sh_nxt;
    logic [N_OBJ-1:0]   w_dir_sh_nxt;

    // The single shared checker compares the store's output with the mouse value latched at start
    mouse_distance_checker u_checker (
        .i_x_obj     (i_obj_x),
        .i_y_obj     (i_obj_y),
        .i_x_mouse   (r_x_mouse),
        .i_y_mouse   (r_y_mouse),
        .o_is_close  (w_is_close),
        .o_direction (w_direction)
    );

    assign w_last = (r_idx == IDX_W'(N_OBJ - 1));

    // Shadow masks with the current object's bit merged in; disabled objects read as 0
    always_comb begin
        w_close_sh_nxt        = r_close_sh;
        w_dir_sh_nxt          = r_dir_sh;
        w_close_sh_nxt[r_idx] = w_is_close  & r_enable[r_idx];
        w_dir_sh_nxt[r_idx]   = w_direction & r_enable[r_idx];
    end

    // State register
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state logic: IDLE waits for a tick, then READ/EVAL alternate per object
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE:  if (i_start) w_state_nxt = S_READ;
            S_READ:  w_state_nxt = S_EVAL;
            S_EVAL:  w_state_nxt = w_last ? S_IDLE : S_READ;
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // Datapath: latch frame inputs, step the index, fill shadow masks, publish at the end
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_idx        <= '0;
            r_x_mouse    <= '0;
            r_y_mouse    <= '0;
            r_enable     <= '0;
            r_close_sh   <= '0;
            r_dir_sh     <= '0;
            r_close_mask <= '0;
            r_dir_mask   <= '0;
            r_any_close  <= 1'b0;
            r_busy       <= 1'b0;
            r_done       <= 1'b0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (i_start) begin
                        r_x_mouse <= i_x_mouse;
                        r_y_mouse <= i_y_mouse;
                        r_enable  <= i_obj_enable;
                        r_idx     <= '0;
                        r_busy    <= 1'b1;
                    end
                end
                S_EVAL: begin
                    r_close_sh <= w_close_sh_nxt;
                    r_dir_sh   <= w_dir_sh_nxt;
                    if (w_last) begin
                        r_close_mask <= w_close_sh_nxt;
                        r_dir_mask   <= w_dir_sh_nxt;
                        r_any_close  <= |w_close_sh_nxt;
                        r_done       <= 1'b1;
                        r_busy       <= 1'b0;
                        r_idx        <= '0;
                    end else begin
                        r_idx <= r_idx + IDX_W'(1);
                    end
                end
                default: ;
            endcase
        end
    end

    assign o_obj_idx    = r_idx;
    assign o_busy       = r_busy;
    assign o_done       = r_done;
    assign o_close_mask = r_close_mask;
    assign o_dir_mask   = r_dir_mask;
    assign o_any_close  = r_any_close;

endmodule
